arcade_input_hub: RTL
=====================

// Module: arcade_input_hub
// PURPOSE
//  Parametrised input front-end for the arcade emu tops. Sits between hps_io and the game core.
//  - Decodes ps2_key into per-player latches and merges them with N joysticks.
//  - Conditions coin inputs into fixed-width pulses.
//  - Captures DIP banks and the game-mod byte from ioctl.
//  - Drives registered control words; per-game bit packing stays in the emu top.
// PARAMETERS
//  NUM_PLAYERS    2     players / joystick inputs (1..4)
//  NUM_DIP_BANKS  8     8-bit DIP banks captured (1..8)
//  NUM_MODS       4     width of mod_onehot
//  DIP_INDEX      254   ioctl_index carrying DIPs
//  MOD_INDEX      1     ioctl_index carrying the mod byte
//  COIN_PULSE_CYC 250000  coin pulse width in clk_sys cycles (>=1)
//  COIN_GAP_CYC   250000  post-pulse lockout in cycles (>=1)
//  AUTOFIRE_HALF  1250000 autofire half-period in cycles (used only with ARCADE_INPUT_AUTOFIRE_EN)
// PORTS
//  clk_sys      in   1          system clock (clk_25 in emu tops)
//  reset        in   1          synchronous, active-high
//  ps2_key      in   11         hps_io key: [10] toggle, [9] pressed, [7:0] code
//  joy          in   16*NP      packed joysticks, player p at [16p+15:16p]
//  joy_merge    in   1          1: OR all joysticks into player 0
//  ioctl_wr     in   1          ioctl write strobe
//  ioctl_index  in   8          ioctl index
//  ioctl_addr   in   25         ioctl address
//  ioctl_dout   in   8          ioctl data
//  ctrl         out  10*NP      per player: [0]R [1]L [2]D [3]U [4]fireA [5]fireB [6]fireC [7]fireD [8]start [9]coin_raw
//  coin_pulse   out  NP         conditioned coin, one pulse per insertion
//  dip          out  8*NDB      bank b at [8b+7:8b]
//  mod_sel      out  8          last mod byte
//  mod_onehot   out  NUM_MODS   bit i = (mod_sel==i), registered
//  autofire_on  out  NP         per-player autofire state
// BEHAVIOUR
//  Reset
//  - ctrl, coin_pulse, autofire_on and all key latches go to 0.
//  - The toggle tracker reloads ps2_key[10], so no key event is taken on the cycle after reset.
//  - dip, mod_sel and mod_onehot ignore reset; they power up at 0, because ROM download asserts reset.
//  PS/2 decode
//  - Event = ps2_key[10] differs from the registered copy. Latch <= ps2_key[9] from code only; [8] is ignored.
//  - P0: 75 U, 72 D, 6B L, 74 R, 14 fireA, 11 fireB, 29 fireC, 12 fireD, 05/16 start, 2E coin.
//  - P1: 2D U, 2B D, 23 L, 34 R, 1C fireA, 1B fireB, 15 fireC, 1D fireD, 06/1E start, 36 coin.
//  - Players 2 and up get no keys. Unlisted codes are ignored.
//  Joystick merge
//  - ctrl[p] = key_p | joy_p: joy bits 0-3 dirs, 4-7 fire A-D, 8 start, 10 coin.
//  - With joy_merge=1, player 0 takes the OR of all joysticks and players 1 and up take keys only.
//  Latency: ctrl is registered.
//  - ps2_key toggle sampled at edge N -> latch at N+1 -> ctrl at N+2.
//  - A joy change appears on ctrl one cycle later.
//  Coin FSM (per player): IDLE, PULSE, GAP.
//  - IDLE -> PULSE on a rising edge of ctrl coin_raw; coin_pulse goes high on the next cycle.
//  - PULSE lasts exactly COIN_PULSE_CYC cycles, then GAP.
//  - GAP lasts exactly COIN_GAP_CYC cycles, then IDLE.
//  - Edges seen in PULSE or GAP are dropped. A held coin gives one pulse; it must be released before the next.
//  - reset mid-PULSE forces IDLE and coin_pulse=0 on the next cycle.
//  ioctl capture
//  - DIP: ioctl_wr && index==DIP_INDEX && addr<NUM_DIP_BANKS writes dip[addr]; other addresses are ignored.
//  - Mod: ioctl_wr && index==MOD_INDEX writes mod_sel at any address, last write wins.
//  - mod_onehot follows mod_sel one cycle later.
//  - mod_sel>=NUM_MODS gives mod_onehot = 0.
// CONFIGURATION
//  ARCADE_INPUT_AUTOFIRE_EN defined:
//  - Key 04 (F3) toggles autofire_on[0] on press; key 0C (F4) toggles autofire_on[1].
//  - While autofire_on[p]=1, ctrl fireA[p] = held AND a square wave: 1 for AUTOFIRE_HALF cycles, then 0 for AUTOFIRE_HALF.
//  - The wave phase restarts high on each fireA press.
//  Not defined:
//  - autofire_on is tied to 0, fireA passes straight through, and F3/F4 are ignored.
// STRUCTURE
//  Package arcade_input_pkg:
//  - CTRL_* bit-index localparams and CTRL_W=10.
//  - PS/2 scancode localparams.
//  - Coin FSM enum coin_st_t {IDLE,PULSE,GAP}.
//  Sub-module arcade_coin_cond: one instance per player; params PULSE_CYC and GAP_CYC; ports clk_sys, reset, coin_in, coin_pulse.
// TESTING
//  T1: ps2 toggle with code 75, pressed=1 -> ctrl[3]=1 two cycles later; release -> 0. Code 2D -> ctrl[13]=1.
//  T2: COIN_PULSE_CYC=4, COIN_GAP_CYC=3; hold joy[10] 20 cycles -> coin_pulse[0] high exactly 4 cycles, once.
//      Re-press during GAP -> no pulse. Re-press after GAP -> second pulse.
//  T3: ioctl index 254 writes addr0=A5, addr1=3C, addr9=FF -> dip[7:0]=A5, dip[15:8]=3C, rest unchanged.
//      Then reset -> dip values retained.
//  T4: ioctl index 1 data 02 -> mod_sel=02, mod_onehot=0100. Data 07 -> mod_onehot=0000.
//  T5: joy_merge=1, joy_1[4]=1 -> ctrl[4]=1 and ctrl[14]=0. joy_merge=0 -> ctrl[14]=1.
//  T6 (with ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_HALF=2): F3 press, hold fireA -> ctrl[4] pattern 1,1,0,0 repeating.
//      Second F3 press -> steady 1.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front-end: control-word bit map, PS/2 scancodes, coin FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package arcade_input_pkg;

   // Per-player control word bit positions
   localparam int CTRL_R     = 0;
   localparam int CTRL_L     = 1;
   localparam int CTRL_D     = 2;
   localparam int CTRL_U     = 3;
   localparam int CTRL_FA    = 4;
   localparam int CTRL_FB    = 5;
   localparam int CTRL_FC    = 6;
   localparam int CTRL_FD    = 7;
   localparam int CTRL_START = 8;
   localparam int CTRL_COIN  = 9;
   localparam int CTRL_W     = 10;

   // Player 0 scancodes
   localparam logic [7:0] SC_P0_U      = 8'h75;
   localparam logic [7:0] SC_P0_D      = 8'h72;
   localparam logic [7:0] SC_P0_L      = 8'h6B;
   localparam logic [7:0] SC_P0_R      = 8'h74;
   localparam logic [7:0] SC_P0_FA     = 8'h14;
   localparam logic [7:0] SC_P0_FB     = 8'h11;
   localparam logic [7:0] SC_P0_FC     = 8'h29;
   localparam logic [7:0] SC_P0_FD     = 8'h12;
   localparam logic [7:0] SC_P0_START  = 8'h05;
   localparam logic [7:0] SC_P0_START2 = 8'h16;
   localparam logic [7:0] SC_P0_COIN   = 8'h2E;

   // Player 1 scancodes
   localparam logic [7:0] SC_P1_U      = 8'h2D;
   localparam logic [7:0] SC_P1_D      = 8'h2B;
   localparam logic [7:0] SC_P1_L      = 8'h23;
   localparam logic [7:0] SC_P1_R      = 8'h34;
   localparam logic [7:0] SC_P1_FA     = 8'h1C;
   localparam logic [7:0] SC_P1_FB     = 8'h1B;
   localparam logic [7:0] SC_P1_FC     = 8'h15;
   localparam logic [7:0] SC_P1_FD     = 8'h1D;
   localparam logic [7:0] SC_P1_START  = 8'h06;
   localparam logic [7:0] SC_P1_START2 = 8'h1E;
   localparam logic [7:0] SC_P1_COIN   = 8'h36;

   // Autofire toggle keys (F3 / F4)
   localparam logic [7:0] SC_AF_P0     = 8'h04;
   localparam logic [7:0] SC_AF_P1     = 8'h0C;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

endpackage

// File: rtl/arcade_coin_cond.sv
// Coin conditioner: one fixed-width pulse per coin_in rising edge, followed by a lockout gap.
// Latency: coin_pulse rises one cycle after the edge is seen; high for PULSE_CYC, then GAP_CYC lockout.
// Backpressure: none; edges arriving during pulse or lockout are dropped.
module arcade_coin_cond
   import arcade_input_pkg::*;
#(
   parameter int PULSE_CYC = 250000,
   parameter int GAP_CYC   = 250000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic coin_in,
   output logic coin_pulse
);

   localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);

   coin_st_t      st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          coin_d;

   // State, phase counter and edge-detect history
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         st     <= IDLE;
         cnt    <= '0;
         coin_d <= 1'b0;
      end else begin
         st     <= st_nxt;
         cnt    <= cnt_nxt;
         coin_d <= coin_in;
      end
   end

   // Next state; the pulse is a pure decode of the registered state
   always_comb begin
      st_nxt     = st;
      cnt_nxt    = cnt;
      coin_pulse = 1'b0;
      case (st)
         IDLE: begin
            cnt_nxt = '0;
            if (coin_in && !coin_d) st_nxt = PULSE;
         end
         PULSE: begin
            coin_pulse = 1'b1;
            if (cnt == P_LAST) begin
               st_nxt  = GAP;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == G_LAST) begin
               st_nxt  = IDLE;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: rtl/arcade_input_hub.sv
// Arcade input front-end: PS/2 key latches merged with joysticks, coin conditioning, DIP/mod capture. Option: ARCADE_INPUT_AUTOFIRE_EN.
// Latency: ps2 toggle sampled at N -> latch N+1 -> ctrl N+2; joy -> ctrl 1 cycle; mod_onehot 1 cycle after mod_sel.
// Backpressure: none; every input is sampled every clk_sys cycle.
module arcade_input_hub
   import arcade_input_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int NUM_DIP_BANKS  = 8,
   parameter int NUM_MODS       = 4,
   parameter int DIP_INDEX      = 254,
   parameter int MOD_INDEX      = 1,
   parameter int COIN_PULSE_CYC = 250000,
   parameter int COIN_GAP_CYC   = 250000,
   parameter int AUTOFIRE_HALF  = 1250000
) (
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic [10:0]                   ps2_key,
   input  logic [16*NUM_PLAYERS-1:0]     joy,
   input  logic                          joy_merge,
   input  logic                          ioctl_wr,
   input  logic [7:0]                    ioctl_index,
   input  logic [24:0]                   ioctl_addr,
   input  logic [7:0]                    ioctl_dout,
   output logic [CTRL_W*NUM_PLAYERS-1:0] ctrl,
   output logic [NUM_PLAYERS-1:0]        coin_pulse,
   output logic [8*NUM_DIP_BANKS-1:0]    dip,
   output logic [7:0]                    mod_sel,
   output logic [NUM_MODS-1:0]           mod_onehot,
   output logic [NUM_PLAYERS-1:0]        autofire_on
);

   logic [9:0]        key_q;      // {toggle, pressed, code}
   logic              tog_d;
   logic              key_evt;
   logic [CTRL_W-1:0] key_p0, key_p1;
   logic [CTRL_W-1:0] joy_c [NUM_PLAYERS];
   logic [CTRL_W-1:0] joy_or;
   logic [CTRL_W-1:0] held  [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] fa_out;
   logic              unused_inputs;

   // The extended-key flag is not part of any mapping
   assign unused_inputs = ^{ps2_key[8], joy};

   // Register the key word; toggle copy reloads on reset so no stale event follows it
   always_ff @(posedge clk_sys) begin
      key_q <= {ps2_key[10:9], ps2_key[7:0]};
      if (reset) tog_d <= ps2_key[10];
      else       tog_d <= key_q[9];
   end

   assign key_evt = (key_q[9] != tog_d);

   // Per-player key latches follow the pressed flag of each recognised code
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         key_p0 <= '0;
         key_p1 <= '0;
      end else if (key_evt) begin
         case (key_q[7:0])
            SC_P0_R:                    key_p0[CTRL_R]     <= key_q[8];
            SC_P0_L:                    key_p0[CTRL_L]     <= key_q[8];
            SC_P0_D:                    key_p0[CTRL_D]     <= key_q[8];
            SC_P0_U:                    key_p0[CTRL_U]     <= key_q[8];
            SC_P0_FA:                   key_p0[CTRL_FA]    <= key_q[8];
            SC_P0_FB:                   key_p0[CTRL_FB]    <= key_q[8];
            SC_P0_FC:                   key_p0[CTRL_FC]    <= key_q[8];
            SC_P0_FD:                   key_p0[CTRL_FD]    <= key_q[8];
            SC_P0_START, SC_P0_START2:  key_p0[CTRL_START] <= key_q[8];
            SC_P0_COIN:                 key_p0[CTRL_COIN]  <= key_q[8];
            SC_P1_R:                    key_p1[CTRL_R]     <= key_q[8];
            SC_P1_L:                    key_p1[CTRL_L]     <= key_q[8];
            SC_P1_D:                    key_p1[CTRL_D]     <= key_q[8];
            SC_P1_U:                    key_p1[CTRL_U]     <= key_q[8];
            SC_P1_FA:                   key_p1[CTRL_FA]    <= key_q[8];
            SC_P1_FB:                   key_p1[CTRL_FB]    <= key_q[8];
            SC_P1_FC:                   key_p1[CTRL_FC]    <= key_q[8];
            SC_P1_FD:                   key_p1[CTRL_FD]    <= key_q[8];
            SC_P1_START, SC_P1_START2:  key_p1[CTRL_START] <= key_q[8];
            SC_P1_COIN:                 key_p1[CTRL_COIN]  <= key_q[8];
            default: ;
         endcase
      end
   end

   // Joystick remap to the control layout (coin lives at joy bit 10) and key/joy merge
   always_comb begin
      joy_or = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         joy_c[p] = {joy[16*p+10], joy[16*p +: 9]};
         joy_or   = joy_or | joy_c[p];
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         held[p] = (p == 0) ? key_p0 : (p == 1) ? key_p1 : '0;
         if (!joy_merge)  held[p] = held[p] | joy_c[p];
         else if (p == 0) held[p] = held[p] | joy_or;
      end
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int AF_CW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
   localparam logic [AF_CW-1:0] AF_LAST = AF_CW'(AUTOFIRE_HALF - 1);

   logic [NUM_PLAYERS-1:0] af_on, fa_d, af_ph, af_ph_nxt, af_press, af_cur_ph;
   logic [AF_CW-1:0]       af_cnt [NUM_PLAYERS];
   logic [AF_CW-1:0]       af_cnt_nxt [NUM_PLAYERS];
   logic [AF_CW-1:0]       af_cur_cnt [NUM_PLAYERS];

   // F3/F4 presses flip the per-player autofire enable
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         af_on <= '0;
      end else if (key_evt && key_q[8]) begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            if (p < 2 && key_q[7:0] == ((p == 0) ? SC_AF_P0 : SC_AF_P1))
               af_on[p] <= ~af_on[p];
      end
   end

   // Square wave per player; a fresh fireA press restarts it at the start of the high half
   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         af_press[p]   = held[p][CTRL_FA] & ~fa_d[p];
         af_cur_ph[p]  = af_press[p] | af_ph[p];
         af_cur_cnt[p] = af_press[p] ? '0 : af_cnt[p];
         fa_out[p]     = held[p][CTRL_FA] & (~af_on[p] | af_cur_ph[p]);
         if (af_cur_cnt[p] == AF_LAST) begin
            af_cnt_nxt[p] = '0;
            af_ph_nxt[p]  = ~af_cur_ph[p];
         end else begin
            af_cnt_nxt[p] = af_cur_cnt[p] + 1'b1;
            af_ph_nxt[p]  = af_cur_ph[p];
         end
      end
   end

   // Wave phase state and fireA press history
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         fa_d  <= '0;
         af_ph <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) af_cnt[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            fa_d[p]   <= held[p][CTRL_FA];
            af_ph[p]  <= af_ph_nxt[p];
            af_cnt[p] <= af_cnt_nxt[p];
         end
      end
   end

   assign autofire_on = af_on;
`else
   localparam int AF_HALF_UNUSED = AUTOFIRE_HALF;

   // Without autofire, fireA is the plain held state
   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) fa_out[p] = held[p][CTRL_FA];
   end

   assign autofire_on = '0;
`endif

   // Registered control words
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ctrl <= '0;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            ctrl[CTRL_W*p +: CTRL_W] <= {held[p][CTRL_W-1:CTRL_FB], fa_out[p], held[p][CTRL_U:CTRL_R]};
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
      arcade_coin_cond #(
         .PULSE_CYC (COIN_PULSE_CYC),
         .GAP_CYC   (COIN_GAP_CYC)
      ) u_coin (
         .clk_sys    (clk_sys),
         .reset      (reset),
         .coin_in    (ctrl[CTRL_W*p + CTRL_COIN]),
         .coin_pulse (coin_pulse[p])
      );
   end

   // DIP and mod capture; no reset so values survive the reset held during ROM download
   always_ff @(posedge clk_sys) begin
      if (ioctl_wr && ioctl_index == 8'(DIP_INDEX)) begin
         for (int b = 0; b < NUM_DIP_BANKS; b++)
            if (ioctl_addr == 25'(b)) dip[8*b +: 8] <= ioctl_dout;
      end
      if (ioctl_wr && ioctl_index == 8'(MOD_INDEX)) mod_sel <= ioctl_dout;
      for (int i = 0; i < NUM_MODS; i++) mod_onehot[i] <= (mod_sel == 8'(i));
   end

endmodule
